// File: rtl/ecdsa_dma_pkg.sv
//------------------------------------------------------------------------------
// ecdsa_dma_pkg
// Shared widths and state encoding for the DMA word responder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ecdsa_dma_pkg;

  localparam int DATA_W     = 381;             // DMA payload width
  localparam int WORD_W     = 32;              // memory word width
  localparam int BEATS      = 12;              // words per transfer
  localparam int PAD_W      = 3;               // zero pad below the payload
  localparam int BUF_W      = DATA_W + PAD_W;  // 384-bit packing buffer
  localparam int BEAT_CNT_W = 4;               // holds 0..BEATS-1

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } dma_state_t;

endpackage

`default_nettype wire

// File: rtl/dma_word_responder.sv
//------------------------------------------------------------------------------
// dma_word_responder
// Turns one 381-bit DMA read/write request into a burst of 12 single-word
// memory transactions and signals completion with a one-cycle done pulse.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dma_word_responder
  import ecdsa_dma_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                dma_rx_start,
  input  logic [31:0]         dma_rx_address,
  output logic [DATA_W-1:0]   dma_rx_data,
  input  logic                dma_tx_start,
  input  logic [31:0]         dma_tx_address,
  input  logic [DATA_W-1:0]   dma_tx_data,
  output logic                dma_done,
  output logic                dma_idle,
  output logic                dma_error,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic [WORD_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  input  logic                mem_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [BEAT_CNT_W-1:0] BEAT_LAST = BEAT_CNT_W'(BEATS - 1);

  dma_state_t              state_q, state_d;
  logic [31:0]             base_q;
  logic [BUF_W-1:0]        buf_q;     // beat k word sits in the top 32 bits when beat k is active
  logic [BEAT_CNT_W-1:0]   beat_q;
  logic [TO_W-1:0]         tcnt_q;
  logic                    error_q;
  logic [DATA_W-1:0]       rx_data_q;

  logic in_wait;
  logic last_beat;
  logic timeout_hit;
  logic misaligned_rx;
  logic misaligned_tx;

  assign in_wait       = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
  assign last_beat     = (beat_q == BEAT_LAST);
  assign timeout_hit   = in_wait && !mem_ack && (tcnt_q == TO_LAST);
  assign misaligned_rx = (dma_rx_address[1:0] != 2'b00);
  assign misaligned_tx = (dma_tx_address[1:0] != 2'b00);

  assign dma_error   = error_q;
  assign dma_rx_data = rx_data_q;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode and state-derived outputs; rx wins over tx on a tie.
  always_comb begin
    state_d   = state_q;
    dma_done  = 1'b0;
    dma_idle  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        dma_idle = 1'b1;
        if (dma_rx_start)      state_d = misaligned_rx ? ST_DONE : ST_RD_REQ;
        else if (dma_tx_start) state_d = misaligned_tx ? ST_DONE : ST_WR_REQ;
      end
      ST_RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = base_q + {26'd0, beat_q, 2'b00};
        state_d  = ST_RD_WAIT;
      end
      ST_WR_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base_q + {26'd0, beat_q, 2'b00};
        mem_wdata = buf_q[BUF_W-1 -: WORD_W];
        state_d   = ST_WR_WAIT;
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (mem_ack) begin
          if (mem_err || last_beat)     state_d = ST_DONE;
          else if (state_q == ST_RD_WAIT) state_d = ST_RD_REQ;
          else                          state_d = ST_WR_REQ;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        dma_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, packing shift register, beat/timeout counters and sticky error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      base_q    <= '0;
      buf_q     <= '0;
      beat_q    <= '0;
      tcnt_q    <= '0;
      error_q   <= 1'b0;
      rx_data_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (dma_rx_start || dma_tx_start) begin
            beat_q <= '0;
            tcnt_q <= '0;
            if (dma_rx_start) begin
              base_q  <= dma_rx_address;
              buf_q   <= '0;
              error_q <= dma_tx_start || misaligned_rx;
            end else begin
              base_q  <= dma_tx_address;
              buf_q   <= {dma_tx_data, {PAD_W{1'b0}}};
              error_q <= misaligned_tx;
            end
          end
        end
        ST_RD_REQ, ST_WR_REQ: tcnt_q <= '0;
        ST_RD_WAIT, ST_WR_WAIT: begin
          if (mem_ack) begin
            if (mem_err) begin
              error_q <= 1'b1;
            end else begin
              // Reads shift the returned word in at the bottom; writes shift the next word up.
              if (state_q == ST_RD_WAIT) buf_q <= {buf_q[BUF_W-WORD_W-1:0], mem_rdata};
              else                       buf_q <= {buf_q[BUF_W-WORD_W-1:0], {WORD_W{1'b0}}};
              if (last_beat) begin
                // Final word's pad bits are dropped.
                if (state_q == ST_RD_WAIT)
                  rx_data_q <= {buf_q[BUF_W-WORD_W-1:0], mem_rdata[WORD_W-1:PAD_W]};
              end else begin
                beat_q <= beat_q + 1'b1;
              end
            end
          end else if (tcnt_q == TO_LAST) begin
            error_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_word_responder.sv
//------------------------------------------------------------------------------
// tb_dma_word_responder
// Directed/randomized bench with a word-memory responder and a payload model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dma_word_responder;

  logic         clk = 1'b0;
  logic         resetn;
  logic         dma_rx_start = 1'b0;
  logic [31:0]  dma_rx_address = '0;
  logic [380:0] dma_rx_data;
  logic         dma_tx_start = 1'b0;
  logic [31:0]  dma_tx_address = '0;
  logic [380:0] dma_tx_data = '0;
  logic         dma_done, dma_idle, dma_error;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata;
  logic [31:0]  mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic         mem_err = 1'b0;

  dma_word_responder #(.TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .dma_rx_start(dma_rx_start), .dma_rx_address(dma_rx_address), .dma_rx_data(dma_rx_data),
    .dma_tx_start(dma_tx_start), .dma_tx_address(dma_tx_address), .dma_tx_data(dma_tx_data),
    .dma_done(dma_done), .dma_idle(dma_idle), .dma_error(dma_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Memory responder state and observation queues.
  logic [31:0] mem [0:1023];
  int          lat = 1;
  bit          withhold = 0;
  int          err_beat = -1;
  int          pend = 0;
  logic [31:0] pend_addr, pend_wdata;
  bit          pend_we;
  logic [31:0] q_addr[$];
  logic [31:0] q_wdata[$];
  bit          q_we[$];
  int          done_pulses = 0;

  // Responds to each mem_req with an ack lat cycles later.
  always begin
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    if (dma_done) done_pulses++;
    if (!resetn) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_ack = 1'b1;
          if (q_addr.size() - 1 == err_beat) mem_err = 1'b1;
          if (pend_we) mem[pend_addr[11:2]] = pend_wdata;
          else         mem_rdata = mem[pend_addr[11:2]];
        end
      end
      if (mem_req) begin
        q_addr.push_back(mem_addr); q_we.push_back(mem_we); q_wdata.push_back(mem_wdata);
        pend_addr = mem_addr; pend_we = mem_we; pend_wdata = mem_wdata;
        if (!withhold) pend = lat;
      end
    end
  end

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: beat k occupies bits [383-32k -: 32] of {payload, 3'b000}.
  function automatic logic [380:0] model_read(input logic [31:0] a);
    logic [383:0] b;
    for (int k = 0; k < 12; k++) b[383-32*k -: 32] = mem[int'(a[11:2]) + k];
    return b[383:3];
  endfunction

  function automatic logic [31:0] model_word(input logic [380:0] d, input int k);
    logic [383:0] b;
    b = {d, 3'b000};
    return b[383-32*k -: 32];
  endfunction

  function automatic logic [380:0] rand_payload();
    logic [383:0] b;
    for (int k = 0; k < 12; k++) b[383-32*k -: 32] = $urandom;
    return b[383:3];
  endfunction

  int   done_cyc;
  logic err_done, idle_after, c1_req, c1_idle;

  // Issues one start in cycle 0 and waits (bounded) for the done pulse.
  task automatic run_xfer(input logic rx, input logic tx, input logic [31:0] a, input logic [380:0] d);
    q_addr.delete(); q_we.delete(); q_wdata.delete();
    dma_rx_address = a; dma_tx_address = a; dma_tx_data = d;
    dma_rx_start = rx; dma_tx_start = tx;
    done_cyc = -1; err_done = 1'bx; c1_req = 1'bx; c1_idle = 1'bx;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk); #1;
      dma_rx_start = 1'b0; dma_tx_start = 1'b0;
      if (c == 1) begin c1_req = mem_req; c1_idle = dma_idle; end
      if (dma_done) begin done_cyc = c; err_done = dma_error; break; end
    end
    @(posedge clk); #1;
    idle_after = dma_idle;
  endtask

  logic [380:0] exp_rx;
  logic [380:0] d;
  int           L, p0, d1, r2, bad;
  logic [31:0]  a;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    exp_rx = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle", dma_idle, 1);
    chk("rst_done", dma_done, 0);
    chk("rst_error", dma_error, 0);
    chk("rst_req_we", {mem_req, mem_we}, 0);
    chk("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
    chk("rst_rx_data", dma_rx_data, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Read, L=1, known pattern.
    for (int k = 0; k < 12; k++) mem[('h100 >> 2) + k] = 32'hA0000000 + k;
    lat = 1;
    run_xfer(1, 0, 32'h100, '0);
    exp_rx = model_read(32'h100);
    chk("rd1_c1_req", c1_req, 1);
    chk("rd1_c1_idle", c1_idle, 0);
    chk("rd1_done_cycle", done_cyc, 25);
    chk("rd1_idle_after", idle_after, 1);
    chk("rd1_nreq", q_addr.size(), 12);
    bad = 0;
    for (int k = 0; k < q_addr.size(); k++) if (q_addr[k] !== 32'h100 + 4*k || q_we[k]) bad++;
    chk("rd1_addr_seq", bad, 0);
    chk("rd1_top_word", dma_rx_data[380:349], 32'hA0000000);
    chk("rd1_error", err_done, 0);
    chk("rd1_rx_data", dma_rx_data, exp_rx);

    // Randomized read with random ack latency.
    for (int t = 0; t < 3; t++) begin
      a = 32'h180 + 32'(t) * 32'h40;
      for (int k = 0; k < 12; k++) mem[int'(a[11:2]) + k] = $urandom;
      L = $urandom_range(1, 3);
      lat = L;
      run_xfer(1, 0, a, '0);
      exp_rx = model_read(a);
      chk("rdr_done_cycle", done_cyc, 1 + 12 * (L + 1));
      chk("rdr_rx_data", dma_rx_data, exp_rx);
      chk("rdr_error", err_done, 0);
    end
    lat = 1;

    // Write all-ones.
    p0 = done_pulses;
    run_xfer(0, 1, 32'h200, {381{1'b1}});
    chk("wr1_nreq", q_addr.size(), 12);
    bad = 0;
    for (int k = 0; k < q_addr.size(); k++)
      if (!q_we[k] || q_addr[k] !== 32'h200 + 4*k || q_wdata[k] !== (k == 11 ? 32'hFFFFFFF8 : 32'hFFFFFFFF)) bad++;
    chk("wr1_beats", bad, 0);
    chk("wr1_done_once", done_pulses - p0, 1);
    chk("wr1_error", err_done, 0);

    // Randomized write checked against memory contents.
    d = rand_payload();
    run_xfer(0, 1, 32'h240, d);
    bad = 0;
    for (int k = 0; k < 12; k++) if (mem[('h240 >> 2) + k] !== model_word(d, k)) bad++;
    chk("wrr_mem", bad, 0);
    chk("wrr_rx_unchanged", dma_rx_data, exp_rx);

    // Simultaneous starts: read wins, error flagged.
    for (int k = 0; k < 12; k++) mem[('h300 >> 2) + k] = $urandom;
    run_xfer(1, 1, 32'h300, rand_payload());
    exp_rx = model_read(32'h300);
    chk("sim_nreq", q_addr.size(), 12);
    bad = 0;
    foreach (q_we[k]) if (q_we[k]) bad++;
    chk("sim_no_tx_beats", bad, 0);
    chk("sim_error", err_done, 1);
    chk("sim_rx_data", dma_rx_data, exp_rx);

    // Held rx start: second burst only once IDLE is seen again.
    q_addr.delete(); q_we.delete(); q_wdata.delete();
    dma_rx_address = 32'h300; dma_rx_start = 1'b1;
    d1 = -1; r2 = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (d1 < 0 && dma_done) d1 = c;
      else if (d1 >= 0 && mem_req) begin r2 = c; break; end
    end
    dma_rx_start = 1'b0;
    chk("hold_done_cycle", d1, 25);
    chk("hold_second_req", r2, 27);
    done_cyc = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (dma_done) begin done_cyc = c; err_done = dma_error; break; end
    end
    chk("hold_second_done", done_cyc, 24);
    chk("hold_error", err_done, 0);
    @(posedge clk); #1;

    // Misaligned read.
    run_xfer(1, 0, 32'h102, '0);
    chk("mis_done_cycle", done_cyc, 1);
    chk("mis_nreq", q_addr.size(), 0);
    chk("mis_error", err_done, 1);
    chk("mis_idle_c2", idle_after, 1);
    chk("mis_rx_unchanged", dma_rx_data, exp_rx);

    // Memory error on beat 5.
    for (int k = 0; k < 12; k++) mem[('h100 >> 2) + k] = $urandom;
    err_beat = 5;
    run_xfer(1, 0, 32'h100, '0);
    err_beat = -1;
    chk("merr_nreq", q_addr.size(), 6);
    chk("merr_error", err_done, 1);
    chk("merr_rx_unchanged", dma_rx_data, exp_rx);

    // Timeout: no ack, TIMEOUT = 8.
    withhold = 1;
    run_xfer(1, 0, 32'h100, '0);
    withhold = 0;
    chk("to_done_cycle", done_cyc, 10);
    chk("to_nreq", q_addr.size(), 1);
    chk("to_error", err_done, 1);
    chk("to_rx_unchanged", dma_rx_data, exp_rx);

    // Reset mid-burst at beat 4.
    p0 = done_pulses;
    q_addr.delete(); q_we.delete(); q_wdata.delete();
    dma_rx_address = 32'h100; dma_rx_start = 1'b1;
    @(posedge clk); #1;
    dma_rx_start = 1'b0;
    for (int c = 0; c < 200 && q_addr.size() < 5; c++) begin @(posedge clk); #1; end
    #2;
    resetn = 1'b0;
    #1;
    chk("rstm_idle", dma_idle, 1);
    chk("rstm_outs", {dma_done, dma_error, mem_req, mem_we, mem_addr, mem_wdata}, 0);
    chk("rstm_rx_data", dma_rx_data, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rstm_nreq", q_addr.size(), 5);
    chk("rstm_no_done", done_pulses - p0, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rstm_idle_after", dma_idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dma_word_responder.md
# dma_word_responder

Memory-side responder for the 381-bit DMA start/done interface driven by the ECDSA top-level controller. It accepts one read request (`dma_rx_start`) or one write request (`dma_tx_start`) at a time. Each request becomes a burst of 12 single-word transactions on a 32-bit memory port, and the responder reports completion with a one-cycle `dma_done` pulse. Simulation benches and the FPGA memory bridge use it so the controller's DMA transfers run against real word-addressed memory.

## Interface
- `DATA_W`, 381: DMA payload width.
- `WORD_W`, 32: memory word width.
- `BEATS`, 12: words per transfer, ceil(381/32).
- `TIMEOUT`, 1024: maximum cycles to wait for `mem_ack` on one beat.

- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `dma_rx_start` in 1: read request, sampled in IDLE only.
- `dma_rx_address` in 32: byte address of the read burst.
- `dma_rx_data` out 381: read payload, registered.
- `dma_tx_start` in 1: write request, sampled in IDLE only.
- `dma_tx_address` in 32: byte address of the write burst.
- `dma_tx_data` in 381: write payload.
- `dma_done` out 1: one-cycle completion pulse.
- `dma_idle` out 1: high while in IDLE.
- `dma_error` out 1: sticky error flag.
- `mem_req` out 1: one-cycle beat request.
- `mem_we` out 1: write enable, qualified by `mem_req`.
- `mem_addr` out 32: beat byte address.
- `mem_wdata` out 32: beat write data.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `mem_ack` in 1: beat completion.
- `mem_err` in 1: beat error, qualified by `mem_ack`.

## Operation
- **States:** IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- **Reset values:**
  - State is IDLE, so `dma_idle` is 1.
  - `dma_done`, `dma_error`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are 0.
  - `dma_rx_data` is 0.
  - Beat counter and timeout counter are 0.
- **Accept (IDLE only):**
  - Latch the address and, for writes, `dma_tx_data`.
  - Clear `dma_error` and the beat counter.
  - If `dma_rx_start` and `dma_tx_start` are both high, rx wins and tx is dropped. `dma_error` is set for that transfer.
  - Starts seen in any state other than IDLE, DONE included, are ignored.
- **Misaligned address** (`addr[1:0]` != 0): no memory access. Go directly to DONE with `dma_error` = 1.
- **Packing:** buf384 = {payload, 3'b000}.
  - Beat k uses `mem_addr` = base + 4k.
  - Beat k carries word buf384[383-32k -: 32].
  - Beat 0 carries the payload MSBs.
  - For reads, `dma_rx_data` = buf384[383:3]; the low 3 bits of beat 11 are discarded.
  - For writes, those 3 bits are driven as 0.
- **REQ state:** `mem_req` = 1 for exactly one cycle, with `mem_we`, `mem_addr` and `mem_wdata` valid. Then go to WAIT.
- **WAIT state:**
  - On `mem_ack`: reads capture `mem_rdata` into the beat slot. After beat 11 go to DONE, otherwise increment the beat counter and go to REQ.
  - `mem_err` with `mem_ack`: set `dma_error` and abort to DONE.
  - No ack within `TIMEOUT` cycles: set `dma_error` and abort to DONE.
- **Read data update:** `dma_rx_data` updates only when a read completes without error. On an aborted read it holds its previous value.
- **DONE state:** `dma_done` = 1 for one cycle, then return to IDLE.
- **Error clearing:** `dma_error` stays set until the next accepted start.

## Timing
- With `dma_rx_start` sampled at the edge ending cycle 0, cycle 1 is RD_REQ with `dma_idle` = 0 and `mem_req` = 1.
- For memory ack latency L ≥ 1 cycles after `mem_req`, `dma_done` is asserted in cycle 1 + 12·(L+1). For L = 1 that is cycle 25. `dma_idle` returns to 1 in cycle 26.
- `dma_rx_data` holds the new value from the `dma_done` cycle until the next successful read.
- A misaligned request gives `dma_done` in cycle 1 and `dma_idle` = 1 in cycle 2.
- An ack arriving in the same cycle as `mem_req` is illegal. Acks seen outside WAIT are ignored.
- The timeout counter restarts at every REQ. An abort occurs on wait-cycle `TIMEOUT`.
- Reset asserted mid-burst returns the block to IDLE immediately with all outputs at reset values. No `dma_done` pulse is produced.

## Structure
- Package `ecdsa_dma_pkg` holds:
  - `DATA_W`, `WORD_W`, `BEATS` and the pad width (3).
  - The state enum encoding.
- Single module, no sub-module. The packing shift register and the beat/timeout counters are local.

## Test plan
- **Read, L=1:** memory word at 0x100+4k = 0xA0000000+k, rx start at 0x100. Require `dma_done` at cycle 25, 12 `mem_req` pulses with ascending addresses, `dma_rx_data[380:349]` = 0xA0000000 and `dma_error` = 0.
- **Write:** tx start at 0x200 with `dma_tx_data` = all-ones. Require beats 0–10 to write 0xFFFFFFFF, beat 11 to write 0xFFFFFFF8, `mem_we` high on every `mem_req`, and `dma_done` once.
- **Simultaneous starts, then held start:** rx and tx start together at 0x300. Require a read burst only, `dma_error` = 1 at done, and no tx beats. Then hold `dma_rx_start` high through DONE and require a second burst only after `dma_idle` = 1.
- **Misaligned and memory error:**
  - rx at 0x102: `dma_done` at cycle 1, no `mem_req`, `dma_error` = 1.
  - `mem_err` on beat 5: abort with 6 `mem_req` pulses total and `dma_rx_data` unchanged.
- **Timeout and reset:**
  - Withhold `mem_ack` with TIMEOUT = 8: `dma_error` = 1 and `dma_done` after 8 wait cycles.
  - Drop `resetn` at beat 4: outputs go to reset values asynchronously, `dma_idle` = 1, and no `dma_done` pulse.
